// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encoding, command polarity and default widths
package mem_arbiter_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-request round-robin grant
//   clk, rst_n : clock, async active-low reset (pointer -> port 0)
//   i_req      : request vector
//   i_update   : advance pointer away from i_last
//   i_last     : index of the port just served
//   o_grant    : one-hot grant (zero when no request)
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_last,
    output logic [1:0] o_grant
);
    logic r_ptr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ptr <= 1'b0;
        else if (i_update) r_ptr <= ~i_last;
    assign o_grant = (&i_req) ? (r_ptr ? 2'b10 : 2'b01) : i_req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin controller for a single MEMORY block
//   clk, reset      : clock, async active-low reset
//   reqN/rwN/addrN/wdataN : requester N command, held until ackN
//   ackN, rdataN    : one-cycle completion pulse, last read data for port N
//   mem_din/addr/rw/valid, mem_dout : MEMORY command and read-data pins
//   busy            : high whenever the FSM is not idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic              mem_valid,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);
    state_t            r_state, w_next;
    logic              r_sel;
    logic [1:0]        r_cnt;
    logic [1:0]        w_grant;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din, r_rd0, r_rd1;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (reset),
        .i_req    ({req1, req0}),
        .i_update (r_state == ST_DONE),
        .i_last   (r_sel),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= ST_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state == ST_IDLE  ? (|w_grant ? ST_ISSUE : ST_IDLE) :
                 r_state == ST_ISSUE ? (r_rw == RW_WRITE ? ST_DONE : ST_WAIT) :
                 r_state == ST_WAIT  ? (r_cnt == 2'd0 ? ST_DONE : ST_WAIT) : ST_IDLE;
        mem_valid = r_state == ST_ISSUE;
        ack0      = r_state == ST_DONE && !r_sel;
        ack1      = r_state == ST_DONE && r_sel;
        busy      = r_state != ST_IDLE;
    end

    // Command registers change only on a new grant so MEMORY sees stable pins.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_sel  <= 1'b0;
            r_cnt  <= 2'd0;
            r_rw   <= RW_READ;
            r_addr <= '0;
            r_din  <= '0;
            r_rd0  <= '0;
            r_rd1  <= '0;
        end else begin
            if (r_state == ST_IDLE && |w_grant) begin
                r_sel  <= w_grant[1];
                r_rw   <= w_grant[1] ? rw1 : rw0;
                r_addr <= w_grant[1] ? addr1 : addr0;
                r_din  <= w_grant[1] ? wdata1 : wdata0;
            end
            if (r_state == ST_ISSUE) r_cnt <= 2'(READ_LAT - 1);
            else if (r_state == ST_WAIT) r_cnt <= r_cnt - 2'd1;
            if (r_state == ST_WAIT && r_cnt == 2'd0) begin
                if (r_sel) r_rd1 <= mem_dout;
                else r_rd0 <= mem_dout;
            end
        end

    assign mem_rw   = r_rw;
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign rdata0   = r_rd0;
    assign rdata1   = r_rd1;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter at READ_LAT 1 and 3
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, mem_rw, mem_valid, busy;
    logic [31:0] rdata0, rdata1, mem_din, mem_dout;
    logic [7:0]  mem_addr;

    logic        t_req0 = 1'b0, t_rw0 = 1'b0, t_req1 = 1'b0, t_rw1 = 1'b0;
    logic [7:0]  t_addr0 = '0, t_addr1 = '0;
    logic [31:0] t_wdata0 = '0, t_wdata1 = '0;
    logic        t_ack0, t_ack1, t_mem_rw, t_mem_valid, t_busy;
    logic [31:0] t_rdata0, t_rdata1, t_mem_din, t_mem_dout;
    logic [7:0]  t_mem_addr;

    int n_vec = 0, n_err = 0;
    int gq[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_din(mem_din), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_valid(mem_valid),
        .mem_dout(mem_dout), .busy(busy)
    );

    mem_arbiter #(.READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0(t_req0), .rw0(t_rw0), .addr0(t_addr0), .wdata0(t_wdata0), .ack0(t_ack0), .rdata0(t_rdata0),
        .req1(t_req1), .rw1(t_rw1), .addr1(t_addr1), .wdata1(t_wdata1), .ack1(t_ack1), .rdata1(t_rdata1),
        .mem_din(t_mem_din), .mem_addr(t_mem_addr), .mem_rw(t_mem_rw), .mem_valid(t_mem_valid),
        .mem_dout(t_mem_dout), .busy(t_busy)
    );

    // Memory models: read data is valid only in the cycle READ_LAT after ISSUE.
    logic [31:0] mem  [256] = '{default: 32'h0};
    logic [31:0] mem3 [256] = '{default: 32'h0};
    logic [3:0]  rp = '0, rp3 = '0;
    always @(posedge clk) begin
        if (mem_valid && mem_rw) mem[mem_addr] <= mem_din;
        if (t_mem_valid && t_mem_rw) mem3[t_mem_addr] <= t_mem_din;
        rp  <= {rp[2:0], mem_valid & ~mem_rw};
        rp3 <= {rp3[2:0], t_mem_valid & ~t_mem_rw};
    end
    assign mem_dout   = rp[0]  ? mem[mem_addr]    : 32'hDEADBEEF;
    assign t_mem_dout = rp3[2] ? mem3[t_mem_addr] : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input logic p, input logic rw, input logic [7:0] a, input logic [31:0] d,
                           input int drop_at, output int lat, output int mv, output int wrong);
        lat = -1; mv = 0; wrong = 0;
        @(negedge clk);
        if (p) begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
        else begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == drop_at) begin req0 = 1'b0; req1 = 1'b0; end
            mv += int'(mem_valid);
            wrong += int'(p ? ack0 : ack1);
            if (n == 1) begin
                chk("issue_rw", 32'(mem_rw), 32'(rw));
                chk("issue_addr", 32'(mem_addr), 32'(a));
                chk("issue_din", mem_din, d);
            end
            if (p ? ack1 : ack0) begin
                lat = n; req0 = 1'b0; req1 = 1'b0;
                chk("done_addr_hold", 32'(mem_addr), 32'(a));
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic race(input int target, input bit hold);
        gq.delete();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 0; n < 60 && gq.size() < target; n++) begin
            @(negedge clk);
            if (ack0) begin gq.push_back(0); if (!hold) req0 = 1'b0; end
            if (ack1) begin gq.push_back(1); if (!hold) req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("race_count", 32'(gq.size()), 32'(target));
        while (gq.size() < target) gq.push_back(9);
    endtask

    task automatic run3(input logic rw, input logic [7:0] a, input logic [31:0] d, output int lat, output int mv);
        lat = -1; mv = 0;
        @(negedge clk);
        t_req0 = 1'b1; t_rw0 = rw; t_addr0 = a; t_wdata0 = d;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            mv += int'(t_mem_valid);
            if (t_ack0) begin lat = n; t_req0 = 1'b0; break; end
        end
        t_req0 = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;
    vec_t vt[10];

    initial begin
        int lat, mv, wrong;
        vt[0] = '{1'b0, 1'b1, 8'h00, 32'h5,        2, 32'h0,        32'h0};
        vt[1] = '{1'b0, 1'b0, 8'h00, 32'h1111,     3, 32'h5,        32'h0};
        vt[2] = '{1'b1, 1'b1, 8'h10, 32'hABCD,     2, 32'h5,        32'h0};
        vt[3] = '{1'b1, 1'b0, 8'h10, 32'h2222,     3, 32'h5,        32'hABCD};
        vt[4] = '{1'b0, 1'b1, 8'h00, 32'h77,       2, 32'h5,        32'hABCD};
        vt[5] = '{1'b1, 1'b0, 8'h00, 32'h3333,     3, 32'h5,        32'h77};
        vt[6] = '{1'b0, 1'b0, 8'hFF, 32'h4444,     3, 32'h0,        32'h77};
        vt[7] = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 2, 32'h0,        32'h77};
        vt[8] = '{1'b0, 1'b0, 8'hFF, 32'h0,        3, 32'hFFFFFFFF, 32'h77};
        vt[9] = '{1'b1, 1'b0, 8'hFF, 32'h0,        3, 32'hFFFFFFFF, 32'hFFFFFFFF};

        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req0 = 1'($urandom); req1 = 1'($urandom); rw0 = 1'($urandom); rw1 = 1'($urandom);
            addr0 = 8'($urandom); addr1 = 8'($urandom); wdata0 = $urandom; wdata1 = $urandom;
            #1;
            chk("reset_outputs", {23'h0, mem_valid, mem_rw, busy, ack0, ack1,
                |mem_addr, |mem_din, |rdata0, |rdata1}, 32'h0);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_no_req", {30'h0, mem_valid, busy}, 32'h0);
        end

        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i].port, vt[i].rw, vt[i].addr, vt[i].wdata, 0, lat, mv, wrong);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_valid_cycles", i), 32'(mv), 32'h1);
            chk($sformatf("v%0d_other_ack", i), 32'(wrong), 32'h0);
            chk($sformatf("v%0d_rdata0", i), rdata0, vt[i].rd0);
            chk($sformatf("v%0d_rdata1", i), rdata1, vt[i].rd1);
        end

        rw0 = 1'b1; addr0 = 8'h2C; wdata0 = 32'hF00; rw1 = 1'b0; addr1 = 8'h2C; wdata1 = 32'h0;
        race(2, 1'b0);
        chk("contend_first", 32'(gq[0]), 32'h0);
        chk("contend_second", 32'(gq[1]), 32'h1);
        chk("contend_rdata1", rdata1, 32'hF00);

        rw0 = 1'b0; addr0 = 8'h2C; rw1 = 1'b0; addr1 = 8'h10;
        race(4, 1'b1);
        for (int i = 0; i < 4; i++) chk($sformatf("fair_grant%0d", i), 32'(gq[i]), 32'(i % 2));
        chk("fair_rdata0", rdata0, 32'hF00);
        chk("fair_rdata1", rdata1, 32'hABCD);

        run_txn(1'b1, 1'b0, 8'h00, 32'h0, 2, lat, mv, wrong);
        chk("drop_latency", 32'(lat), 32'h3);
        chk("drop_rdata1", rdata1, 32'h77);
        chk("drop_rdata0_kept", rdata0, 32'hF00);

        run_txn(1'b0, 1'b1, 8'h30, 32'h3030, 0, lat, mv, wrong);
        chk("wr30_latency", 32'(lat), 32'h2);
        chk("wr30_rdata0_kept", rdata0, 32'hF00);

        @(negedge clk);
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h30;
        @(negedge clk);
        chk("midrd_issue", 32'(mem_valid), 32'h1);
        @(negedge clk);
        chk("midrd_wait_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("midrd_reset_outs", {26'h0, mem_valid, ack0, ack1, busy, |mem_addr, |rdata0}, 32'h0);
        req0 = 1'b0;
        @(negedge clk);
        chk("midrd_reset_hold", {29'h0, mem_valid, ack0, busy}, 32'h0);
        reset = 1'b1;
        rw0 = 1'b1; addr0 = 8'h31; wdata0 = 32'h31; rw1 = 1'b0; addr1 = 8'h30;
        race(2, 1'b0);
        chk("post_reset_first", 32'(gq[0]), 32'h0);
        chk("post_reset_second", 32'(gq[1]), 32'h1);
        chk("post_reset_rdata1", rdata1, 32'h3030);

        run3(1'b1, 8'h40, 32'h12345678, lat, mv);
        chk("lat3_wr_latency", 32'(lat), 32'h2);
        run3(1'b0, 8'h40, 32'h0, lat, mv);
        chk("lat3_rd_latency", 32'(lat), 32'h5);
        chk("lat3_rd_valid_cycles", 32'(mv), 32'h1);
        chk("lat3_rd_rdata0", t_rdata0, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
